// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction memory loader: state
// encoding, frame geometry and the instruction word width used by the pipeline.
package mips_loader_pkg;

  localparam int INSTR_W        = 32;
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  // States in which the loader is willing to take a stream byte.
  function automatic logic takes_byte(input loader_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs stream bytes MSB-first into 32-bit words while keeping a running XOR
// of every data byte; word_full flags the byte that completes a word.
module word_assembler
  import mips_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic [7:0]         checksum,
  output logic               word_full
);

  logic [INSTR_W-1:0] word_q, word_d;
  logic [7:0]         xor_q, xor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    xor_d  = xor_q;
    cnt_d  = cnt_q;
    if (load_clear) begin
      word_d = '0;
      xor_d  = '0;
      cnt_d  = '0;
    end else if (byte_en) begin
      word_d = {word_q[INSTR_W-9:0], byte_in};
      xor_d  = xor_q ^ byte_in;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      xor_q  <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      xor_q  <= xor_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word      = word_q;
  assign checksum  = xor_q;
  assign word_full = byte_en && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Write side of the instruction memory: parses a length/data/checksum byte
// frame, writes words to consecutive addresses and releases the CPU on success.
module inst_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [INSTR_W-1:0] mem_data,
  output logic               mem_wren,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words_loaded
);

  loader_state_t      state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_now;
  logic [ADDR_W:0]    words_loaded_q, words_loaded_d, words_inc;
  logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
  logic               accept;
  logic               load_clear;
  logic               data_en;
  logic               word_full;
  logic [7:0]         checksum;
  logic [INSTR_W-1:0] word;

  assign accept     = byte_valid && byte_ready;
  assign len_now    = {len_q[LEN_W-1:8], byte_in};
  assign words_inc  = words_loaded_q + 1'b1;
  assign data_en    = accept && (state_q == DATA);
  // A new load may only begin from a resting state, never mid-frame.
  assign load_clear = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .load_clear (load_clear),
    .byte_en    (data_en),
    .byte_in    (byte_in),
    .word       (word),
    .checksum   (checksum),
    .word_full  (word_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      words_loaded_q <= '0;
      mem_address_q  <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      words_loaded_q <= words_loaded_d;
      mem_address_q  <= mem_address_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN_HI;
      LEN_HI:          if (accept) state_d = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_now == '0)                      state_d = CHK;
          else if (len_now > LEN_W'(MAX_WORDS))   state_d = ERR;
          else                                    state_d = DATA;
        end
      end
      DATA:            if (word_full) state_d = WRITE;
      WRITE:           state_d = (LEN_W'(words_inc) == len_q) ? CHK : DATA;
      CHK:             if (accept) state_d = (byte_in == checksum) ? DONE : ERR;
      default:         state_d = IDLE;
    endcase
  end

  // Counters advance as the WRITE cycle retires, so the address seen during
  // the write pulse is the count of words already stored.
  always_comb begin
    len_d          = len_q;
    words_loaded_d = words_loaded_q;
    mem_address_d  = mem_address_q;
    if (load_clear) begin
      len_d          = '0;
      words_loaded_d = '0;
      mem_address_d  = '0;
    end else if (accept && (state_q == LEN_HI)) begin
      len_d = {byte_in, len_q[7:0]};
    end else if (accept && (state_q == LEN_LO)) begin
      len_d = len_now;
    end else if (state_q == WRITE) begin
      words_loaded_d = words_inc;
      mem_address_d  = mem_address_q + 1'b1;
    end
  end

  always_comb begin
    byte_ready   = takes_byte(state_q);
    mem_wren     = (state_q == WRITE);
    mem_address  = mem_address_q;
    mem_data     = word;
    cpu_hold     = (state_q != DONE);
    done         = (state_q == DONE);
    error        = (state_q == ERR);
    words_loaded = words_loaded_q;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: frames are queued with their expected
// memory writes, and a negedge monitor checks every write pulse as it appears.
module tb_inst_mem_loader;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  int          compared;
  int          mismatched;
  wr_t         exp_q[$];
  logic [31:0] mem_model [1024];

  inst_mem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                              input logic exp_hold, input logic [10:0] exp_words);
    checkOutput({name, "_done"}, done, exp_done);
    checkOutput({name, "_error"}, error, exp_err);
    checkOutput({name, "_cpu_hold"}, cpu_hold, exp_hold);
    checkOutput({name, "_words_loaded"}, words_loaded, exp_words);
  endtask

  // Every write pulse must match the oldest outstanding expected write.
  always @(negedge clock) begin
    wr_t e;
    if (reset && mem_wren) begin
      mem_model[mem_address] = mem_data;
      checkOutput("byte_ready_in_write", byte_ready, 1'b0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write_addr", mem_address, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", mem_address, e.addr);
        checkOutput("write_data", mem_data, e.data);
      end
    end
  end

  // Called and returns just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!byte_ready) begin
      checkOutput("byte_ready_timeout", byte_ready, 1'b1);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Sends a frame; pulse_idx >= 0 pulses start just before that byte.
  task automatic applyStimulus(input logic [7:0] frame[$], input bit gaps, input int pulse_idx);
    foreach (frame[i]) begin
      if (i == pulse_idx) pulse_start();
      send_byte(frame[i]);
      if (gaps) @(negedge clock);
    end
  endtask

  task automatic build_frame(input logic [31:0] words[$], input logic [7:0] chk_flip,
                             output logic [7:0] frame[$]);
    logic [7:0]  x;
    logic [15:0] n;
    logic [31:0] w;
    frame = {};
    x = 8'h00;
    n = 16'(words.size());
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 3; b >= 0; b--) begin
        frame.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
      exp_q.push_back('{addr: 10'(i), data: w});
    end
    frame.push_back(x ^ chk_flip);
  endtask

  initial begin
    logic [7:0]  frame[$];
    logic [31:0] words[$];

    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    reset      = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_status("reset", 1'b0, 1'b0, 1'b1, 11'd0);
    checkOutput("reset_byte_ready", byte_ready, 1'b0);
    checkOutput("reset_mem_wren", mem_wren, 1'b0);
    checkOutput("reset_mem_address", mem_address, 32'd0);
    checkOutput("reset_mem_data", mem_data, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_status("idle", 1'b0, 1'b0, 1'b1, 11'd0);

    $display("[TB] single word load");
    exp_q.push_back('{addr: 10'd0, data: 32'h2008_0005});
    frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    pulse_start();
    checkOutput("len_hi_ready", byte_ready, 1'b1);
    applyStimulus(frame, 1'b0, -1);
    check_status("single", 1'b1, 1'b0, 1'b0, 11'd1);

    pulse_start();
    check_status("restart_from_done", 1'b0, 1'b0, 1'b1, 11'd0);

    // Each byte value occurs four times, so the XOR of this frame is zero.
    $display("[TB] three words with stalls");
    words = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222};
    build_frame(words, 8'h00, frame);
    checkOutput("three_word_checksum", frame[14], 8'h00);
    applyStimulus(frame, 1'b1, -1);
    check_status("three_words", 1'b1, 1'b0, 1'b0, 11'd3);

    $display("[TB] bad checksum then recovery");
    exp_q.push_back('{addr: 10'd0, data: 32'h2008_0005});
    frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    pulse_start();
    applyStimulus(frame, 1'b0, -1);
    check_status("bad_checksum", 1'b0, 1'b1, 1'b1, 11'd1);
    exp_q.push_back('{addr: 10'd0, data: 32'h2008_0005});
    frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    pulse_start();
    checkOutput("error_cleared", error, 1'b0);
    applyStimulus(frame, 1'b0, -1);
    check_status("recovered", 1'b1, 1'b0, 1'b0, 11'd1);

    $display("[TB] length boundaries");
    frame = '{8'h04, 8'h01};
    pulse_start();
    applyStimulus(frame, 1'b0, -1);
    check_status("len_1025", 1'b0, 1'b1, 1'b1, 11'd0);
    checkOutput("len_1025_ready", byte_ready, 1'b0);
    frame = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    applyStimulus(frame, 1'b0, -1);
    check_status("len_zero", 1'b1, 1'b0, 1'b0, 11'd0);

    words = {};
    for (int i = 0; i < 1024; i++) words.push_back({16'(i), ~16'(i)});
    build_frame(words, 8'h00, frame);
    pulse_start();
    applyStimulus(frame, 1'b0, -1);
    check_status("len_1024", 1'b1, 1'b0, 1'b0, 11'd1024);

    $display("[TB] reset during load");
    exp_q.push_back('{addr: 10'd0, data: 32'hA1B2_C3D4});
    frame = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h55, 8'h66};
    pulse_start();
    applyStimulus(frame, 1'b0, -1);
    reset = 1'b0;
    #1;
    check_status("mid_reset", 1'b0, 1'b0, 1'b1, 11'd0);
    checkOutput("mid_reset_byte_ready", byte_ready, 1'b0);
    checkOutput("mid_reset_mem_address", mem_address, 32'd0);
    checkOutput("mid_reset_mem_data", mem_data, 32'd0);
    checkOutput("mid_reset_mem_wren", mem_wren, 1'b0);
    checkOutput("mid_reset_mem0_kept", mem_model[0], 32'hA1B2_C3D4);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    words = '{32'hDEAD_BEEF};
    build_frame(words, 8'h00, frame);
    pulse_start();
    applyStimulus(frame, 1'b0, -1);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 11'd1);

    $display("[TB] start ignored mid-frame");
    words = '{32'h0123_4567, 32'h89AB_CDEF};
    build_frame(words, 8'h00, frame);
    pulse_start();
    applyStimulus(frame, 1'b0, 4);
    check_status("start_mid_frame", 1'b1, 1'b0, 1'b0, 11'd2);

    @(negedge clock);
    @(negedge clock);
    checkOutput("pending_writes", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
